// File: rtl/uart_rx.sv
// UART receiver: start-bit detect, mid-bit sampling, 7/8 data bits, optional parity, 1/2 stop bits.
// Optional 2-flop input synchroniser enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] buad_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       stop_error
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | half-period wait, then confirm the start bit is still low
  // DATA   | sample and shift in data bits, LSB first
  // PARITY | sample and check the parity bit
  // STOP   | sample one or two stop bits
  // DONE   | one-cycle delivery of the received byte
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  // Bit periods rounded to the nearest clock count
  localparam int P_2400  = (CLK_HZ + 1200) / 2400;
  localparam int P_4800  = (CLK_HZ + 2400) / 4800;
  localparam int P_9600  = (CLK_HZ + 4800) / 9600;
  localparam int P_19200 = (CLK_HZ + 9600) / 19200;

  localparam logic [14:0] PM1_2400  = 15'(P_2400 - 1);
  localparam logic [14:0] PM1_4800  = 15'(P_4800 - 1);
  localparam logic [14:0] PM1_9600  = 15'(P_9600 - 1);
  localparam logic [14:0] PM1_19200 = 15'(P_19200 - 1);
  localparam logic [14:0] HM1_2400  = 15'(P_2400 / 2 - 1);
  localparam logic [14:0] HM1_4800  = 15'(P_4800 / 2 - 1);
  localparam logic [14:0] HM1_9600  = 15'(P_9600 / 2 - 1);
  localparam logic [14:0] HM1_19200 = 15'(P_19200 / 2 - 1);

  function automatic logic [14:0] period_m1(input logic [1:0] sel);
    logic [14:0] v;
    case (sel)
      2'b00:   v = PM1_2400;
      2'b01:   v = PM1_4800;
      2'b10:   v = PM1_9600;
      default: v = PM1_19200;
    endcase
    return v;
  endfunction

  function automatic logic [14:0] half_m1(input logic [1:0] sel);
    logic [14:0] v;
    case (sel)
      2'b00:   v = HM1_2400;
      2'b01:   v = HM1_4800;
      2'b10:   v = HM1_9600;
      default: v = HM1_19200;
    endcase
    return v;
  endfunction

  state_t      state, state_next;
  logic        line;
  logic        prev_line;
  logic [14:0] tmr;
  logic        tmr_tc;
  logic        tmr_load;
  logic [14:0] tmr_val;

  logic [1:0]  cfg_baud;
  logic [1:0]  cfg_par;
  logic        cfg_stop2;
  logic        cfg_len8;

  logic [7:0]  shift_q;
  logic        par_acc;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;

  logic        capture;
  logic        shift_en;
  logic        par_chk;
  logic        stop_chk;
  logic        deliver;
  logic        last_bit;
  logic        last_stop;
  logic        par_en;
  logic        par_bad;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], data_in};
  end

  assign line = sync_q[1];
`else
  assign line = data_in;
`endif

  // Held through DONE so a falling edge landing there is still seen in IDLE
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)               prev_line <= 1'b1;
    else if (state != DONE) prev_line <= line;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)              tmr <= '0;
    else if (tmr_load)     tmr <= tmr_val;
    else if (tmr != '0)    tmr <= tmr - 15'd1;
  end

  assign tmr_tc    = (tmr == '0);
  assign last_bit  = (bit_cnt == (cfg_len8 ? 3'd7 : 3'd6));
  assign last_stop = !cfg_stop2 || stop_cnt;
  assign par_en    = ^cfg_par;
  assign par_bad   = (cfg_par == 2'b01) ? ~(par_acc ^ line) : (par_acc ^ line);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = period_m1(cfg_baud);
    capture    = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        if (prev_line && !line) begin
          capture    = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = half_m1(buad_rate);
          state_next = START;
        end
      end
      START: begin
        if (tmr_tc) begin
          if (!line) begin
            tmr_load   = 1'b1;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tmr_tc) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (last_bit) state_next = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tmr_tc) begin
          par_chk    = 1'b1;
          tmr_load   = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (tmr_tc) begin
          stop_chk = 1'b1;
          if (last_stop) begin
            deliver    = 1'b1;
            state_next = DONE;
          end else begin
            tmr_load = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cfg_baud     <= 2'b00;
      cfg_par      <= 2'b00;
      cfg_stop2    <= 1'b0;
      cfg_len8     <= 1'b0;
      shift_q      <= '0;
      par_acc      <= 1'b0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      data_out     <= '0;
    end else begin
      if (capture) begin
        cfg_baud     <= buad_rate;
        cfg_par      <= parity_type;
        cfg_stop2    <= stop_bits;
        cfg_len8     <= data_length;
        shift_q      <= '0;
        par_acc      <= 1'b0;
        bit_cnt      <= '0;
        stop_cnt     <= 1'b0;
        parity_error <= 1'b0;
        stop_error   <= 1'b0;
      end
      if (shift_en) begin
        shift_q <= {line, shift_q[7:1]};
        par_acc <= par_acc ^ line;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_chk && par_bad) parity_error <= 1'b1;
      if (stop_chk) begin
        stop_cnt <= 1'b1;
        if (!line) stop_error <= 1'b1;
      end
      // A 7-bit frame leaves its data in the upper seven shift bits
      if (deliver) data_out <= cfg_len8 ? shift_q : {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rx_active <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      rx_active <= (state_next == START) || (state_next == DATA) ||
                   (state_next == PARITY) || (state_next == STOP);
      rx_done   <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, built with CLK_HZ = 5 MHz to keep frames short.
module tb_uart_rx;

  // Bit periods at 5 MHz: round(5e6/baud); half = P/2 truncated
  localparam int P19200 = 260;
  localparam int H19200 = 130;
  localparam int P9600  = 521;
  localparam int P4800  = 1042;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic       clock = 1'b0;
  logic       rst;
  logic [1:0] buad_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic       data_in;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int act_cnt = 0;
  int overlap = 0;
  logic [7:0] log_data [0:15];
  logic       log_perr [0:15];
  logic       log_serr [0:15];
  int         log_cyc  [0:15];

  uart_rx #(.CLK_HZ(5_000_000)) dut (
    .clock(clock),
    .rst(rst),
    .buad_rate(buad_rate),
    .parity_type(parity_type),
    .stop_bits(stop_bits),
    .data_length(data_length),
    .data_in(data_in),
    .data_out(data_out),
    .rx_active(rx_active),
    .rx_done(rx_done),
    .parity_error(parity_error),
    .stop_error(stop_error)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_active) act_cnt = act_cnt + 1;
    if (rx_done) begin
      if (rx_active) overlap = overlap + 1;
      if (n_done < 16) begin
        log_data[n_done] = data_out;
        log_perr[n_done] = parity_error;
        log_serr[n_done] = stop_error;
        log_cyc[n_done]  = cyc;
      end
      n_done = n_done + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input logic stop0,
                            input int p);
    data_in = 1'b0;
    wait_cyc(p);
    for (int i = 0; i < nbits; i++) begin
      data_in = d[i];
      wait_cyc(p);
    end
    if (par_en) begin
      data_in = par_bit;
      wait_cyc(p);
    end
    for (int s = 0; s < nstop; s++) begin
      data_in = (s == 0) ? stop0 : 1'b1;
      wait_cyc(p);
    end
    data_in = 1'b1;
  endtask

  task automatic set_cfg(input logic [1:0] b, input logic [1:0] pt, input logic sb, input logic dl);
    buad_rate   = b;
    parity_type = pt;
    stop_bits   = sb;
    data_length = dl;
  endtask

  initial begin
    #(80000 * 20);
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int start_cyc;
    logic [7:0] rd;

    rst = 1'b0;
    data_in = 1'b1;
    set_cfg(2'b11, 2'b00, 1'b0, 1'b0);
    wait_cyc(3);
    check_eq("reset data_out", data_out, 8'h00);
    check_eq("reset rx_active", rx_active, 1'b0);
    check_eq("reset rx_done", rx_done, 1'b0);
    check_eq("reset parity_error", parity_error, 1'b0);
    check_eq("reset stop_error", stop_error, 1'b0);
    rst = 1'b1;
    wait_cyc(20);

    // 19200 7N1 0x5D; config inputs scrambled mid-frame must be ignored
    base = n_done;
    start_cyc = cyc;
    fork
      send_frame(8'h5D, 7, 1'b0, 1'b0, 1, 1'b1, P19200);
      begin
        wait_cyc(500);
        set_cfg(2'b00, 2'b01, 1'b1, 1'b1);
      end
    join
    wait_cyc(50);
    set_cfg(2'b11, 2'b00, 1'b0, 1'b0);
    check_eq("t1 done count", n_done - base, 1);
    check_eq("t1 data", log_data[base], 8'h5D);
    check_eq("t1 perr", log_perr[base], 1'b0);
    check_eq("t1 serr", log_serr[base], 1'b0);
    check_eq("t1 latency", log_cyc[base] - start_cyc, 1 + H19200 + 8 * P19200 + SYNC_DLY);
    check_eq("t1 active idle", rx_active, 1'b0);

    // 9600 7O2 0x53, good parity then bad parity
    set_cfg(2'b10, 2'b01, 1'b1, 1'b0);
    base = n_done;
    send_frame(8'h53, 7, 1'b1, 1'b1, 2, 1'b1, P9600);
    wait_cyc(50);
    check_eq("t2a done count", n_done - base, 1);
    check_eq("t2a data", log_data[base], 8'h53);
    check_eq("t2a perr", log_perr[base], 1'b0);
    check_eq("t2a serr", log_serr[base], 1'b0);
    base = n_done;
    send_frame(8'h53, 7, 1'b1, 1'b0, 2, 1'b1, P9600);
    wait_cyc(200);
    check_eq("t2b done count", n_done - base, 1);
    check_eq("t2b data", log_data[base], 8'h53);
    check_eq("t2b perr", log_perr[base], 1'b1);
    check_eq("t2b perr held", parity_error, 1'b1);

    // 19200 8E1 0x95 (parity 0), stop bit low
    set_cfg(2'b11, 2'b10, 1'b0, 1'b1);
    base = n_done;
    send_frame(8'h95, 8, 1'b1, 1'b0, 1, 1'b0, P19200);
    wait_cyc(50);
    check_eq("t3 done count", n_done - base, 1);
    check_eq("t3 data", log_data[base], 8'h95);
    check_eq("t3 serr", log_serr[base], 1'b1);
    check_eq("t3 perr", log_perr[base], 1'b0);

    // False start: line low 100 cycles (< H) at 19200
    set_cfg(2'b11, 2'b00, 1'b0, 1'b1);
    base = n_done;
    act_cnt = 0;
    data_in = 1'b0;
    wait_cyc(100);
    data_in = 1'b1;
    wait_cyc(300);
    check_eq("t4 active cycles", act_cnt, H19200);
    check_eq("t4 no done", n_done - base, 0);
    check_eq("t4 active idle", rx_active, 1'b0);

    // Back-to-back 4800 8N1 frames, zero gap
    set_cfg(2'b01, 2'b00, 1'b0, 1'b1);
    base = n_done;
    send_frame(8'hD9, 8, 1'b0, 1'b0, 1, 1'b1, P4800);
    send_frame(8'h26, 8, 1'b0, 1'b0, 1, 1'b1, P4800);
    wait_cyc(50);
    check_eq("t5 done count", n_done - base, 2);
    check_eq("t5 data0", log_data[base], 8'hD9);
    check_eq("t5 data1", log_data[base + 1], 8'h26);
    check_eq("t5 err1", {log_perr[base + 1], log_serr[base + 1]}, 2'b00);

    // Reset during data bit 3 at 19200 8N1, then clean 0x45
    set_cfg(2'b11, 2'b00, 1'b0, 1'b1);
    base = n_done;
    rd = 8'hB7;
    data_in = 1'b0;
    wait_cyc(P19200);
    for (int i = 0; i < 3; i++) begin
      data_in = rd[i];
      wait_cyc(P19200);
    end
    data_in = rd[3];
    wait_cyc(P19200 / 2);
    check_eq("t6 active before rst", rx_active, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("t6 rst data_out", data_out, 8'h00);
    check_eq("t6 rst rx_active", rx_active, 1'b0);
    check_eq("t6 rst rx_done", rx_done, 1'b0);
    wait_cyc(10);
    data_in = 1'b1;
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(3 * P19200);
    check_eq("t6 no done", n_done - base, 0);
    send_frame(8'h45, 8, 1'b0, 1'b0, 1, 1'b1, P19200);
    wait_cyc(50);
    check_eq("t6 clean count", n_done - base, 1);
    check_eq("t6 clean data", log_data[base], 8'h45);
    check_eq("t6 clean errs", {parity_error, stop_error}, 2'b00);

    check_eq("done/active overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the `uart_tx` transmitter, run from the same 50 MHz system clock. It accepts the frame formats `uart_tx` produces:
- 7 or 8 data bits, sent LSB first;
- optional odd or even parity;
- 1 or 2 stop bits;
- four baud rates.

It detects the start bit, samples each bit at mid-period, and delivers the data byte with a one-cycle `rx_done` pulse plus error flags. It sits on the receive pin, upstream of whatever consumes the bytes.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency, used to derive the bit-period counts below.

Ports:
- Reset style is fixed: one clock; reset is asynchronous and active-low.
- `clock`  in  1  system clock.
- `rst`  in  1  asynchronous active-low reset.
- `buad_rate`  in  2  baud select: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- `parity_type`  in  2  parity select: 00 = none, 01 = odd, 10 = even, 11 = none.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `data_length`  in  1  0 = 7 data bits, 1 = 8 data bits.
- `data_in`  in  1  serial line; idles high.
- `data_out`  out  8  received byte. For 7-bit frames, bit 7 is 0.
- `rx_active`  out  1  high while a frame is being received.
- `rx_done`  out  1  one-cycle pulse when a frame completes.
- `parity_error`  out  1  parity mismatch in the last frame.
- `stop_error`  out  1  a stop bit was sampled low in the last frame.

## Operation
Bit period P in clock cycles:
- 2400 baud: 20833.
- 4800 baud: 10417.
- 9600 baud: 5208.
- 19200 baud: 2604.
- The counter is 15 bits wide.
- H = P/2, truncated.

The state machine has six states: IDLE, START, DATA, PARITY, STOP, DONE.
- **IDLE**
  - Wait for a falling edge on the (synchronised) line.
  - On the edge, latch all four configuration inputs for the whole frame; later changes to them are ignored until the next frame.
  - Clear both error flags, then go to START.
- **START**
  - Count H cycles, then sample the line.
  - Line low: go to DATA.
  - Line high (false start): go to IDLE. No `rx_done` pulse, no error flag.
- **DATA**
  - Sample every P cycles and shift in LSB first.
  - Take 7 or 8 samples, then go to PARITY if parity is enabled, otherwise STOP.
- **PARITY**
  - Sample once, P cycles after the last data bit.
  - Odd parity expects the count of ones (data plus parity bit) to be odd; even parity expects it to be even.
  - A mismatch sets `parity_error`.
- **STOP**
  - Sample 1 or 2 stop bits, each P cycles apart.
  - Any stop bit sampled low sets `stop_error`.
  - After the last stop sample, go to DONE.
- **DONE**
  - Update `data_out`, pulse `rx_done` for one cycle, return to IDLE.
  - The error flags and `data_out` hold until the next start is detected.
- `rx_active` is high in START through STOP.
- A frame with errors is still delivered with `rx_done`; the consumer checks the flags.

## Timing
- Reset values: `data_out` = 0, `rx_active` = 0, `rx_done` = 0, both error flags = 0; the state machine is in IDLE.
- Reset asserted mid-frame aborts immediately: no `rx_done` pulse and no output update.
- Sampling schedule after the detected falling edge (plus synchroniser delay when enabled):
  - start bit at H cycles;
  - data bit k at H + (k+1)·P cycles.
- `rx_done` is asserted 1 cycle after the last stop-bit sample.
- `rx_active` drops in the same cycle `rx_done` rises.
- The last stop bit is sampled at mid-bit. IDLE is re-entered about P/2 before the line would end the stop bit, so back-to-back frames with zero idle gap are received without loss.
- A falling edge that occurs in the DONE cycle is caught in the following IDLE cycle; edge detection compares the current and previous sample.

## Configuration
- Macro `UART_RX_SYNC_EN`:
  - Defined: `data_in` passes through a 2-flop synchroniser before edge detection. All sample points shift 2 cycles later.
  - Undefined: `data_in` is used directly. For use only when the source is already synchronous to `clock`.

## Test plan
- 19200 baud, no parity, 1 stop, 7-bit, driven by `uart_tx` with 0x5D -> `rx_done` pulses once, `data_out` = 0x5D, no error flags.
- 9600 baud, odd parity, 2 stop, 7-bit, 0x53 with parity bit 1 -> `data_out` = 0x53, `parity_error` = 0. Same frame with parity bit forced to 0 -> `parity_error` = 1, `rx_done` still pulses.
- 19200 baud, even parity, 1 stop, 8-bit, 0x95, stop bit forced low -> `data_out` = 0x95, `stop_error` = 1.
- Line low for 1000 cycles then high, at 19200 baud -> false start: returns to IDLE, `rx_done` never pulses, `rx_active` drops after 1302 cycles.
- Two back-to-back 8-bit frames, 0xD9 then 0x26, zero idle gap, 4800 baud -> two `rx_done` pulses, with `data_out` = 0xD9 then 0x26.
- `rst` pulled low during data bit 3 -> all outputs return to 0 asynchronously. A clean frame of 0x45 after release is received correctly.
